wb_arbiter: RTL and testbench

//  Writeback arbiter directly upstream of the physical register file. Collects completed

---
 rtl/wb_arbiter_if.sv | 27 ++
 rtl/wb_arbiter.sv | 108 ++++++++++
 tb/tb_wb_arbiter.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus bundle: functional-unit result inputs with their
// ready back-pressure, plus the regfile write / CDB broadcast lanes.
// The slave modport is the arbiter; the master modport is the FU/regfile side.
interface wb_arbiter_if #(
    parameter int NUM_FU   = 4,
    parameter int WB_PORTS = 2,
    parameter int TAG_W    = 6,
    parameter int DATA_W   = 32
);
    logic [NUM_FU-1:0]                fu_valid;
    logic [NUM_FU-1:0][TAG_W-1:0]     fu_tag;
    logic [NUM_FU-1:0][DATA_W-1:0]    fu_data;
    logic [NUM_FU-1:0]                fu_ready;
    logic [WB_PORTS-1:0]              write_en;
    logic [WB_PORTS-1:0][TAG_W-1:0]   write_idx;
    logic [WB_PORTS-1:0][DATA_W-1:0]  write_data;

    modport master (
        output fu_valid, fu_tag, fu_data,
        input  fu_ready, write_en, write_idx, write_data
    );

    modport slave (
        input  fu_valid, fu_tag, fu_data,
        output fu_ready, write_en, write_idx, write_data
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter in front of the physical register file.
// Each functional unit owns a one-entry holding register. Every cycle up to
// WB_PORTS held results are granted in rotating order starting at r_rrPtr and
// packed onto the low write lanes. Write outputs come only from the holding
// registers (and flush), so there is no combinational path from fu_* to write_*.
module wb_arbiter #(
    parameter int NUM_FU   = 4,
    parameter int WB_PORTS = 2,
    parameter int TAG_W    = 6,
    parameter int DATA_W   = 32
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         flush,
    wb_arbiter_if.slave  bus
);

    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [NUM_FU-1:0]                r_holdValid;
    logic [NUM_FU-1:0][TAG_W-1:0]     r_holdTag;
    logic [NUM_FU-1:0][DATA_W-1:0]    r_holdData;
    logic [PTR_W-1:0]                 r_rrPtr;

    logic [NUM_FU-1:0]                w_grant;
    logic [NUM_FU-1:0]                w_fuReady;
    logic [NUM_FU-1:0]                w_accept;
    logic [WB_PORTS-1:0]              w_writeEn;
    logic [WB_PORTS-1:0][TAG_W-1:0]   w_writeIdx;
    logic [WB_PORTS-1:0][DATA_W-1:0]  w_writeData;
    logic [PTR_W-1:0]                 w_lastIdx;
    int                               w_grantCnt;

    // Rotating scan over the holding registers: the k-th valid entry found
    // from r_rrPtr onward is granted and placed on lane k; flush grants nothing.
    always_comb begin
        w_grant     = '0;
        w_writeEn   = '0;
        w_writeIdx  = '0;
        w_writeData = '0;
        w_grantCnt  = 0;
        w_lastIdx   = r_rrPtr;
        if (!flush) begin
            for (int j = 0; j < NUM_FU; j++) begin
                for (int i = 0; i < NUM_FU; i++) begin
                    if ((((int'(r_rrPtr) + j) % NUM_FU) == i) && r_holdValid[i]
                        && (w_grantCnt < WB_PORTS)) begin
                        w_grant[i] = 1'b1;
                        for (int k = 0; k < WB_PORTS; k++) begin
                            if (k == w_grantCnt) begin
                                w_writeEn[k]   = 1'b1;
                                w_writeIdx[k]  = r_holdTag[i];
                                w_writeData[k] = r_holdData[i];
                            end
                        end
                        w_grantCnt = w_grantCnt + 1;
                        w_lastIdx  = PTR_W'(i);
                    end
                end
            end
        end
    end

    // An FU can hand over a result when its slot is empty or being drained this
    // cycle; during flush everything is accepted and thrown away.
    always_comb begin
        w_fuReady = flush ? '1 : (~r_holdValid | w_grant);
        w_accept  = bus.fu_valid & w_fuReady;
    end

    // Holding registers: flush wins, then a new result (tag 0 has no
    // destination and is swallowed), otherwise a granted entry empties.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_holdValid <= '0;
            r_holdTag   <= '0;
            r_holdData  <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (flush) begin
                    r_holdValid[i] <= 1'b0;
                end else if (w_accept[i]) begin
                    r_holdValid[i] <= (bus.fu_tag[i] != '0);
                    r_holdTag[i]   <= bus.fu_tag[i];
                    r_holdData[i]  <= bus.fu_data[i];
                end else if (w_grant[i]) begin
                    r_holdValid[i] <= 1'b0;
                end
            end
        end
    end

    // Priority pointer moves just past the last granted FU, so the next scan
    // starts with whoever was skipped; it holds when nothing is granted.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rrPtr <= '0;
        end else if (w_grantCnt > 0) begin
            r_rrPtr <= (int'(w_lastIdx) == NUM_FU - 1) ? '0 : w_lastIdx + 1'b1;
        end
    end

    assign bus.fu_ready   = w_fuReady;
    assign bus.write_en   = w_writeEn;
    assign bus.write_idx  = w_writeIdx;
    assign bus.write_data = w_writeData;

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter (NUM_FU=4, WB_PORTS=2). Directed vectors push the
// hand-derived write-lane sequence into a queue; a negedge monitor pops and
// compares every asserted write lane against it.
module tb_wb_arbiter;

    localparam int NUM_FU   = 4;
    localparam int WB_PORTS = 2;
    localparam int TAG_W    = 6;
    localparam int DATA_W   = 32;

    typedef struct {
        int                lane;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic clock;
    logic reset_n;
    logic flush;

    exp_t expQ[$];
    exp_t expItem;
    int   errors;
    int   checks;
    logic window;
    int   grantCount[NUM_FU];
    int   seq[NUM_FU];
    logic [NUM_FU-1:0] acc;

    wb_arbiter_if #(.NUM_FU(NUM_FU), .WB_PORTS(WB_PORTS), .TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

    wb_arbiter #(.NUM_FU(NUM_FU), .WB_PORTS(WB_PORTS), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .flush   (flush),
        .bus     (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Hard stop in case something stalls the stimulus.
    initial begin
        #50000;
        $display("[TB] FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] timeout");
    end

    task automatic expectWrite(input int lane, input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data);
        exp_t e;
        e.lane = lane;
        e.tag  = tag;
        e.data = data;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic [NUM_FU-1:0] v,
                                 input logic [NUM_FU-1:0][TAG_W-1:0] t,
                                 input logic [NUM_FU-1:0][DATA_W-1:0] d);
        @(posedge clock);
        #1;
        bus.fu_valid = v;
        bus.fu_tag   = t;
        bus.fu_data  = d;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 20) begin
            @(negedge clock);
            #1;
            n++;
        end
        checkOutput(name, 32'(expQ.size()), 32'd0);
        repeat (2) @(negedge clock);
    endtask

    function automatic logic [TAG_W-1:0] t6Tag(input int fu, input int s);
        return TAG_W'(fu * 16 + s + 1);
    endfunction

    function automatic logic [DATA_W-1:0] t6Data(input int fu, input int s);
        return 32'hC000_0000 | DATA_W'(fu << 8) | DATA_W'(s);
    endfunction

    // Scoreboard monitor: every asserted lane must match the next expected
    // entry, and idle lanes must present zero tag and data.
    always @(negedge clock) begin
        for (int k = 0; k < WB_PORTS; k++) begin
            if (bus.write_en[k]) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_write: lane %0d got tag %0d data %h, required no write",
                             k, bus.write_idx[k], bus.write_data[k]);
                end else begin
                    expItem = expQ.pop_front();
                    if (expItem.lane != k || expItem.tag !== bus.write_idx[k] || expItem.data !== bus.write_data[k]) begin
                        errors++;
                        $display("[TB] FAIL lane_write: got lane %0d tag %0d data %h, required lane %0d tag %0d data %h",
                                 k, bus.write_idx[k], bus.write_data[k], expItem.lane, expItem.tag, expItem.data);
                    end
                end
                if (window) grantCount[int'(bus.write_idx[k][5:4])]++;
            end else begin
                checks++;
                if (bus.write_idx[k] !== '0 || bus.write_data[k] !== '0) begin
                    errors++;
                    $display("[TB] FAIL idle_lane_zero: lane %0d got tag %0d data %h, required 0 and 0",
                             k, bus.write_idx[k], bus.write_data[k]);
                end
            end
        end
    end

    initial begin
        errors  = 0;
        checks  = 0;
        window  = 1'b0;
        for (int i = 0; i < NUM_FU; i++) grantCount[i] = 0;
        reset_n = 1'b0;
        flush   = 1'b0;
        bus.fu_valid = '0;
        bus.fu_tag   = '0;
        bus.fu_data  = '0;

        // Reset state
        #2;
        checkOutput("reset_write_en", 32'(bus.write_en), 32'h0);
        checkOutput("reset_fu_ready", 32'(bus.fu_ready), 32'hF);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // All four FUs deliver at once; FU0/1 refill while being drained
        expectWrite(0, 6'd5,  32'hA000_0005);
        expectWrite(1, 6'd6,  32'hA000_0006);
        expectWrite(0, 6'd7,  32'hA000_0007);
        expectWrite(1, 6'd8,  32'hA000_0008);
        expectWrite(0, 6'd12, 32'hA000_000C);
        expectWrite(1, 6'd13, 32'hA000_000D);
        applyStimulus(4'b1111, {6'd8, 6'd7, 6'd6, 6'd5},
                      {32'hA000_0008, 32'hA000_0007, 32'hA000_0006, 32'hA000_0005});
        @(negedge clock);
        checkOutput("t2_ready_empty", 32'(bus.fu_ready), 32'hF);
        applyStimulus(4'b0011, {6'd0, 6'd0, 6'd13, 6'd12},
                      {32'h0, 32'h0, 32'hA000_000D, 32'hA000_000C});
        @(negedge clock);
        checkOutput("t2_ready_grant01", 32'(bus.fu_ready), 32'h3);
        applyStimulus(4'b0000, '0, '0);
        @(negedge clock);
        checkOutput("t2_ready_grant23", 32'(bus.fu_ready), 32'hC);
        @(negedge clock);
        checkOutput("t2_ready_grant01_b", 32'(bus.fu_ready), 32'hF);
        waitDrain("t2_drain");

        // Single FU streaming one result per cycle
        expectWrite(0, 6'd9,  32'hB000_0009);
        expectWrite(0, 6'd10, 32'hB000_000A);
        expectWrite(0, 6'd11, 32'hB000_000B);
        applyStimulus(4'b0100, {6'd0, 6'd9, 6'd0, 6'd0}, {32'h0, 32'hB000_0009, 32'h0, 32'h0});
        applyStimulus(4'b0100, {6'd0, 6'd10, 6'd0, 6'd0}, {32'h0, 32'hB000_000A, 32'h0, 32'h0});
        @(negedge clock);
        checkOutput("t3_ready2_a", 32'(bus.fu_ready[2]), 32'h1);
        applyStimulus(4'b0100, {6'd0, 6'd11, 6'd0, 6'd0}, {32'h0, 32'hB000_000B, 32'h0, 32'h0});
        @(negedge clock);
        checkOutput("t3_ready2_b", 32'(bus.fu_ready[2]), 32'h1);
        applyStimulus(4'b0000, '0, '0);
        @(negedge clock);
        checkOutput("t3_ready_last", 32'(bus.fu_ready), 32'hF);
        waitDrain("t3_drain");

        // Tag 0 is accepted but never written
        applyStimulus(4'b0010, {6'd0, 6'd0, 6'd0, 6'd0}, {32'h0, 32'h0, 32'h0000_DEAD, 32'h0});
        @(negedge clock);
        checkOutput("t4_ready1", 32'(bus.fu_ready[1]), 32'h1);
        applyStimulus(4'b0000, '0, '0);
        @(negedge clock);
        checkOutput("t4_write_en", 32'(bus.write_en), 32'h0);
        checkOutput("t4_ready_all", 32'(bus.fu_ready), 32'hF);
        repeat (2) @(negedge clock);

        // Flush with all four slots held and a result arriving
        applyStimulus(4'b1111, {6'd23, 6'd22, 6'd21, 6'd20},
                      {32'hD000_0017, 32'hD000_0016, 32'hD000_0015, 32'hD000_0014});
        applyStimulus(4'b0001, {6'd0, 6'd0, 6'd0, 6'd30}, {32'h0, 32'h0, 32'h0, 32'hD000_001E});
        flush = 1'b1;
        @(negedge clock);
        checkOutput("t5_flush_write_en", 32'(bus.write_en), 32'h0);
        checkOutput("t5_flush_ready", 32'(bus.fu_ready), 32'hF);
        applyStimulus(4'b0000, '0, '0);
        flush = 1'b0;
        @(negedge clock);
        checkOutput("t5_after_write_en", 32'(bus.write_en), 32'h0);
        checkOutput("t5_after_ready", 32'(bus.fu_ready), 32'hF);
        repeat (2) @(negedge clock);

        // Continuous traffic on all FUs for 20 cycles: pairs {3,0} and {1,2} alternate
        for (int c = 1; c <= 21; c++) begin
            if (c % 2 == 1) begin
                expectWrite(0, t6Tag(3, (c - 1) / 2), t6Data(3, (c - 1) / 2));
                expectWrite(1, t6Tag(0, (c - 1) / 2), t6Data(0, (c - 1) / 2));
            end else begin
                expectWrite(0, t6Tag(1, (c - 2) / 2), t6Data(1, (c - 2) / 2));
                expectWrite(1, t6Tag(2, (c - 2) / 2), t6Data(2, (c - 2) / 2));
            end
        end
        for (int i = 0; i < NUM_FU; i++) seq[i] = 0;
        acc = '0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clock);
            #1;
            for (int i = 0; i < NUM_FU; i++) if (acc[i]) seq[i]++;
            if (c == 1) window = 1'b1;
            for (int i = 0; i < NUM_FU; i++) begin
                bus.fu_valid[i] = 1'b1;
                bus.fu_tag[i]   = t6Tag(i, seq[i]);
                bus.fu_data[i]  = t6Data(i, seq[i]);
            end
            @(negedge clock);
            acc = bus.fu_ready;
        end
        @(posedge clock);
        #1;
        bus.fu_valid = '0;
        @(posedge clock);
        #1;
        window = 1'b0;
        waitDrain("t6_drain");
        for (int i = 0; i < NUM_FU; i++) checkOutput($sformatf("t6_grants_fu%0d", i), 32'(grantCount[i]), 32'd10);

        // Asynchronous reset while results are held
        applyStimulus(4'b1111, {6'd43, 6'd42, 6'd41, 6'd40},
                      {32'hE000_002B, 32'hE000_002A, 32'hE000_0029, 32'hE000_0028});
        @(posedge clock);
        #2;
        bus.fu_valid = '0;
        reset_n = 1'b0;
        #1;
        checkOutput("t7_async_write_en", 32'(bus.write_en), 32'h0);
        checkOutput("t7_async_ready", 32'(bus.fu_ready), 32'hF);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        expectWrite(0, 6'd49, 32'hF000_0031);
        expectWrite(1, 6'd50, 32'hF000_0032);
        applyStimulus(4'b1001, {6'd50, 6'd0, 6'd0, 6'd49}, {32'hF000_0032, 32'h0, 32'h0, 32'hF000_0031});
        @(negedge clock);
        checkOutput("t7_post_write_en", 32'(bus.write_en), 32'h0);
        checkOutput("t7_post_ready", 32'(bus.fu_ready), 32'hF);
        applyStimulus(4'b0000, '0, '0);
        waitDrain("t7_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
